// File: rtl/vector_lane_alu_seq.sv
// vector_lane_alu_seq -- lane-serial vector ALU stage.
//
// Captures operand vector A and operand B, where B is either the register
// vector or the broadcast immediate. It then computes LPC lanes per clock on
// a single shared datapath, and presents the full result vector through a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid / in_ready  request handshake (accepted only in IDLE)
//   op                   3-bit operation code
//   use_imm              1: B = imm_vec, 0: B = vec_b
//   vec_a, vec_b,        LANES*N operand vectors, lane i at [i*N +: N]
//   imm_vec
//   out_valid/out_ready  result handshake
//   result               LANES*N result vector
//   busy                 high while in RUN or DONE
//
// Optional build macro: VALU_SAT_ADD_EN
//   defined   : op 111 = unsigned saturating add
//   undefined : op 111 = pass B (immediate broadcast write-through)

module vector_lane_alu_lane #(
   parameter int N = 32
) (
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);
   localparam int SW = $clog2(N);

   logic [N:0] sum;

   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      y   = '0;
      case (op)
         3'b000: y = sum[N-1:0];
         3'b001: y = a - b;
         3'b010: y = a & b;
         3'b011: y = a | b;
         3'b100: y = a ^ b;
         3'b101: y = a << b[SW-1:0];
         3'b110: y = a >> b[SW-1:0];
`ifdef VALU_SAT_ADD_EN
         3'b111: y = sum[N] ? '1 : sum[N-1:0];
`else
         3'b111: y = b;
`endif
         default: y = '0;
      endcase
   end
endmodule

module vector_lane_alu_seq #(
   parameter int N     = 32,
   parameter int LANES = 8,
   parameter int LPC   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic               use_imm,
   input  logic [LANES*N-1:0] vec_a,
   input  logic [LANES*N-1:0] vec_b,
   input  logic [LANES*N-1:0] imm_vec,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*N-1:0] result,
   output logic               busy
);
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

   if ((LANES % LPC) != 0) begin : g_cfg_err
      $error("vector_lane_alu_seq: LANES must be a multiple of LPC");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                     state;
   logic [2:0]                 op_q;
   logic [LANES-1:0][N-1:0]    a_q, b_q, res_q;
   logic [IW-1:0]              idx;

   logic [LPC-1:0][IW-1:0]     lane_sel;
   logic [LPC-1:0][N-1:0]      lane_y;

   // One shared LPC-wide slice; idx walks it across the captured vector.
   for (genvar g = 0; g < LPC; g++) begin : g_lane
      assign lane_sel[g] = idx + IW'(g);
      vector_lane_alu_lane #(.N(N)) u_lane (
         .op (op_q),
         .a  (a_q[lane_sel[g]]),
         .b  (b_q[lane_sel[g]]),
         .y  (lane_y[g])
      );
   end

   assign result = res_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_q     <= op;
               a_q      <= vec_a;
               b_q      <= use_imm ? imm_vec : vec_b;
               idx      <= '0;
               state    <= RUN;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
            RUN: begin
               // Only the current LPC lanes are written; the rest keep
               // whatever they held until their turn comes.
               for (int g = 0; g < LPC; g++)
                  res_q[lane_sel[g]] <= lane_y[g];
               if (idx == IW'(LANES - LPC)) begin
                  idx       <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  idx <= idx + IW'(LPC);
               end
            end
            DONE: if (out_ready) begin
               // in_ready comes back one cycle later, so no accept in DONE.
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vector_lane_alu_seq.sv
module tb_vector_lane_alu_seq;
   localparam int N     = 32;
   localparam int LANES = 8;
   localparam int LPC   = 2;
   localparam int W     = LANES * N;
   localparam int NV    = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = '0;
   logic         use_imm = 1'b0;
   logic [W-1:0] vec_a = '0, vec_b = '0, imm_vec = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         busy;

   vector_lane_alu_seq #(.N(N), .LANES(LANES), .LPC(LPC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .use_imm(use_imm), .vec_a(vec_a), .vec_b(vec_b),
      .imm_vec(imm_vec), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [2:0]   op;
      logic         use_imm;
      logic [W-1:0] a, b, imm, exp;
   } vec_t;

   vec_t         tbl [NV];
   int           total = 0;
   int           bad = 0;
   logic [W-1:0] prev = '0;

   function automatic logic [W-1:0] bc(input logic [N-1:0] x);
      logic [W-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*N +: N] = x;
      return r;
   endfunction

   task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Issue one request, check latency, partial fill, result, optional
   // backpressure hold, and return to IDLE.
   task automatic run_vec(input vec_t v, input int hold);
      int lat;
      logic [W-1:0] part;
      @(negedge clk);
      op = v.op; use_imm = v.use_imm; vec_a = v.a; vec_b = v.b; imm_vec = v.imm;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      op = 3'($urandom); use_imm = ~use_imm;
      vec_a = {8{$urandom}}; vec_b = {8{$urandom}}; imm_vec = {8{$urandom}};
      check({v.name, " in_ready low in RUN"}, W'(in_ready), W'(0));
      check({v.name, " busy in RUN"}, W'(busy), W'(1));
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (lat == 1) begin
            part = prev;
            part[LPC*N-1:0] = v.exp[LPC*N-1:0];
            check({v.name, " partial after first RUN cycle"}, result, part);
         end
      end
      check({v.name, " latency"}, W'(lat), W'(LANES / LPC));
      check({v.name, " result"}, result, v.exp);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; vec_a = {8{$urandom}}; op = 3'($urandom);
         @(posedge clk);
         @(negedge clk);
         check({v.name, " hold out_valid"}, W'(out_valid), W'(1));
         check({v.name, " hold result"}, result, v.exp);
         check({v.name, " hold in_ready"}, W'(in_ready), W'(0));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({v.name, " idle after out_ready"}, {out_valid, in_ready, busy}, W'(3'b010));
      prev = v.exp;
   endtask

   initial begin
      int lat;
      tbl[0] = '{"add_imm", 3'b000, 1'b1, '0, bc(32'hDEAD), bc(32'h5), '0};
      for (int i = 0; i < LANES; i++) begin
         tbl[0].a[i*N +: N]   = N'(i);
         tbl[0].exp[i*N +: N] = N'(5 + i);
      end
      tbl[1] = '{"sub_wrap", 3'b001, 1'b0, bc(32'h0), bc(32'h1), bc(32'h7), bc(32'hFFFFFFFF)};
      tbl[2] = '{"sll_5bit", 3'b101, 1'b0, bc(32'h1), '0, bc(32'h0), '0};
      for (int i = 0; i < LANES; i++) begin
         tbl[2].b[i*N +: N]   = N'(33 + i);
         tbl[2].exp[i*N +: N] = 32'h2 << i;
      end
      tbl[3] = '{"and_imm", 3'b010, 1'b1, bc(32'hF0F0F0F0), bc(32'h0), bc(32'hFF00FF00), bc(32'hF000F000)};
      tbl[4] = '{"or_reg", 3'b011, 1'b0, bc(32'hF0F0F0F0), bc(32'h0F0F0000), bc(32'h0), bc(32'hFFFFF0F0)};
      tbl[5] = '{"xor_reg", 3'b100, 1'b0, bc(32'hAAAA5555), bc(32'hFFFF0000), bc(32'h1), bc(32'h55555555)};
      tbl[6] = '{"srl_5bit", 3'b110, 1'b0, bc(32'h80000000), bc(32'h3F), bc(32'h0), bc(32'h1)};
`ifdef VALU_SAT_ADD_EN
      tbl[7] = '{"op7_sat", 3'b111, 1'b1, bc(32'hFFFFFFF0), bc(32'h99), bc(32'h20), bc(32'hFFFFFFFF)};
`else
      tbl[7] = '{"op7_passb", 3'b111, 1'b1, bc(32'hFFFFFFF0), bc(32'h99), bc(32'h20), bc(32'h20)};
`endif
      tbl[8] = '{"add_wrap", 3'b000, 1'b0, bc(32'hFFFFFFFF), bc(32'h2), bc(32'h64), bc(32'h1)};
      tbl[9] = '{"srl_lanes", 3'b110, 1'b0, bc(32'h80000000), '0, bc(32'h0), '0};
      for (int i = 0; i < LANES; i++) begin
         tbl[9].b[i*N +: N]   = N'(i);
         tbl[9].exp[i*N +: N] = 32'h80000000 >> i;
      end

      // Reset / idle
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset in_ready/out_valid/busy", {out_valid, in_ready, busy}, W'(3'b010));
      check("reset result", result, '0);

      for (int k = 0; k < NV; k++) run_vec(tbl[k], 0);

      // Backpressure: result held for 6 cycles, DONE ignores new requests
      run_vec(tbl[4], 6);

      // Mid-run reset: drop rst_n two cycles after accept
      @(negedge clk);
      op = tbl[0].op; use_imm = tbl[0].use_imm; vec_a = tbl[0].a; vec_b = tbl[0].b;
      imm_vec = tbl[0].imm; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst ctrl", {out_valid, in_ready, busy}, W'(3'b010));
      check("midrst result", result, '0);
      lat = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) lat++;
      end
      check("midrst no out_valid", W'(lat), '0);
      prev = '0;
      run_vec(tbl[0], 0);
      run_vec(tbl[7], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vector_lane_alu_seq.md
Name: vector_lane_alu_seq

Overview:
- Lane-serial vector ALU stage directly downstream of the immediate-broadcast extend unit and the vector register file read ports.
- Captures operand vector A plus operand B, selected as either the register vector or the extended (broadcast) immediate vector.
- Processes LPC lanes per clock and returns the full result vector through a valid/ready handshake.
- Trades latency for area: one LPC-wide datapath is reused across all lanes.

Parameters:
- N, 32, lane width in bits.
- LANES, 8, lanes per vector.
- LPC, 2, lanes processed per clock. LANES % LPC must be 0; otherwise elaboration fails via $error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- op  in  3  operation code.
- use_imm  in  1  1: B = imm_vec; 0: B = vec_b.
- vec_a  in  LANES*N  operand A, lane i at bits [i*N +: N].
- vec_b  in  LANES*N  register operand B.
- imm_vec  in  LANES*N  broadcast immediate from the extend unit.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  LANES*N  result vector.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset values (rst_n low at a clk edge): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; lane index=0; captured operands=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: capture op, vec_a, and B (mux by use_imm, sampled in that cycle); clear lane index; go to RUN.
- RUN:
  - in_ready=0.
  - Each clock computes lanes idx..idx+LPC-1 into the result register, then idx += LPC.
  - When idx+LPC == LANES, that edge also moves to DONE.
  - RUN lasts exactly LANES/LPC cycles.
  - Untouched result lanes keep their previous values until written.
- DONE:
  - out_valid=1; result stable.
  - On out_ready, go to IDLE. in_ready returns the following cycle; there is no accept in the DONE cycle.
- Latency: request accepted at edge E → out_valid high after edge E+LANES/LPC (defaults: 4 cycles).
- Peak throughput: one vector per LANES/LPC+2 cycles when out_ready is held high.
- Ops, all modulo 2^N, per lane, with a=A lane and b=B lane:
  - 000 ADD a+b
  - 001 SUB a-b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL a<<b[$clog2(N)-1:0]
  - 110 SRL logical a>>b[$clog2(N)-1:0]
  - 111 see Optional Feature.
- Input changes during RUN/DONE are ignored; operands are held in internal registers.
- rst_n low in any state, including mid-RUN: immediate return to reset values; the partial result is discarded.
- When LPC == LANES, RUN lasts 1 cycle.

Optional Feature:
- Macro: VALU_SAT_ADD_EN.
- Defined: op 111 = unsigned saturating add; lane = (a+b ≥ 2^N) ? 2^N-1 : a+b.
- Undefined: op 111 = pass B (lane = b), so the immediate broadcast can be written straight through.
- No other behaviour or timing differs between the two builds.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, release → in_ready=1, out_valid=0, busy=0, result=0.
- Immediate ADD:
  - Stimulus: use_imm=1, imm_vec all lanes 0x05, vec_a lanes = i (0..7), op=000.
  - Response: result lanes 5..12; out_valid rises exactly 4 cycles after accept.
- Register SUB wrap:
  - Stimulus: vec_a lane = 0, vec_b lane = 1, op=001.
  - Response: every lane 0xFFFFFFFF.
  - SLL with b=33: lane a=1 → 0x2, since the shift amount uses only 5 bits.
- Backpressure: out_ready=0 for 6 cycles after out_valid → result and out_valid held stable, in_ready=0, new in_valid ignored. out_ready=1 → IDLE next cycle.
- Mid-run reset: assert rst_n=0 two cycles after accept → next edge state IDLE, result=0, out_valid never asserted. A following request completes correctly.
- op 111:
  - Stimulus: a=0xFFFFFFF0, b=0x20.
  - VALU_SAT_ADD_EN defined → 0xFFFFFFFF.
  - Undefined → 0x00000020.
